// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcodes, operand-B select,
// FSM states and FLAGS bit positions.
// ALU_DIV_EN adds the DIV state and the divide helpers.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'h00,
    OP_SUB  = 5'h01,
    OP_MUL  = 5'h02,
    OP_SRL1 = 5'h03,
    OP_SLL1 = 5'h04,
    OP_ROR1 = 5'h05,
    OP_ROL1 = 5'h06,
    OP_NOT  = 5'h07,
    OP_AND  = 5'h08,
    OP_OR   = 5'h09,
    OP_XOR  = 5'h0A,
    OP_NAND = 5'h0B,
    OP_NOR  = 5'h0C,
    OP_XNOR = 5'h0D,
    OP_INC  = 5'h0E,
    OP_DEC  = 5'h0F,
    OP_MULS = 5'h10,
    OP_SLL  = 5'h11,
    OP_SRL  = 5'h12,
    OP_SRA  = 5'h13,
    OP_DIVU = 5'h14,
    OP_REMU = 5'h15,
    OP_SLT  = 5'h16,
    OP_SLTU = 5'h17
  } op_t;

  typedef enum logic [1:0] {
    MOVI_REG  = 2'b00,
    MOVI_MEM  = 2'b01,
    MOVI_IMM  = 2'b10,
    MOVI_ZERO = 2'b11
  } movi_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SINGLE,
    S_MUL_WAIT,
    S_MUL_LO,
    S_MUL_HI
`ifdef ALU_DIV_EN
    , S_DIV
`endif
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULS);
  endfunction

`ifdef ALU_DIV_EN
  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction
`endif

endpackage

// File: rtl/alu_pipe_if.sv
// Request/result bundle between the issue logic (master) and the ALU (slave).
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             ACT;
  logic [4:0]       OP;
  logic [1:0]       MOVI;
  logic [WIDTH-1:0] REG_A;
  logic [WIDTH-1:0] REG_B;
  logic [WIDTH-1:0] MEM;
  logic [WIDTH-1:0] IMM;
  logic [WIDTH-1:0] DATA;
  logic             RDY;
  logic             VLD;
  logic             LAST;
  logic [3:0]       FLAGS;
  logic             ERR;

  modport master (
    output ACT, OP, MOVI, REG_A, REG_B, MEM, IMM,
    input  DATA, RDY, VLD, LAST, FLAGS, ERR
  );

  modport slave (
    input  ACT, OP, MOVI, REG_A, REG_B, MEM, IMM,
    output DATA, RDY, VLD, LAST, FLAGS, ERR
  );
endinterface

// File: rtl/alu_mul_pipe.sv
// Signed/unsigned WIDTHxWIDTH multiplier retimed over MUL_STAGES registers.
// The last stage holds its value until the next product arrives, so the
// caller can read both halves on consecutive cycles.
module alu_mul_pipe #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  input  logic               valid,
  output logic [2*WIDTH-1:0] prod,
  output logic               prod_vld
);

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] p_r [MUL_STAGES];
  logic [MUL_STAGES-1:0] v_r;

  // Extend operands to 2*WIDTH; the truncated product is exact for both signednesses.
  always_comb begin
    ext_a = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    ext_b = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    raw   = ext_a * ext_b;
  end

  // Valid shift chain; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= '0;
    end else begin
      v_r[0] <= valid;
      for (int i = 1; i < MUL_STAGES; i++) v_r[i] <= v_r[i-1];
    end
  end

  // Data stages load only behind a valid so the final stage holds between products.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) p_r[i] <= '0;
    end else begin
      if (valid) p_r[0] <= raw;
      for (int i = 1; i < MUL_STAGES; i++) begin
        if (v_r[i-1]) p_r[i] <= p_r[i-1];
      end
    end
  end

  assign prod     = p_r[MUL_STAGES-1];
  assign prod_vld = v_r[MUL_STAGES-1];

endmodule

// File: rtl/alu_pipe.sv
// Multi-cycle execute-stage ALU with a pipelined multiplier and status flags.
// Optional restoring divider is built only when ALU_DIV_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------
// S_IDLE     | ready, waiting for ACT
// S_SINGLE   | single-beat result on DATA (also the divider result)
// S_MUL_WAIT | product still in the multiplier pipe
// S_MUL_LO   | product low word, LAST=0
// S_MUL_HI   | product high word, LAST=1
// S_DIV      | one quotient bit per cycle, WIDTH cycles
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 1,
  parameter int SHW        = $clog2(WIDTH)
) (
  input logic       CLK,
  input logic       RST,
  alu_pipe_if.slave bus
);

  localparam logic [1:0] WAIT_INIT = (MUL_STAGES > 1) ? 2'(MUL_STAGES - 2) : 2'd0;

  state_t             state, state_nxt;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q, b_sel;
  logic [1:0]         wait_cnt;
  logic               acc;
  logic [2*WIDTH-1:0] prod;
  logic               prod_vld;

  logic [WIDTH-1:0]   res, ar_x, ar_y, ar_y_eff;
  logic [WIDTH:0]     ar_sum;
  logic               ar_inv, cf, vf, illegal, div_zero;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]   quo_q, rem_q;
  logic [SHW-1:0]     div_cnt;
  logic [WIDTH:0]     rem_sh, rem_sub;
`endif

  assign acc = bus.ACT && (state == S_IDLE);

  // Operand-B source select.
  always_comb begin
    case (movi_t'(bus.MOVI))
      MOVI_REG: b_sel = bus.REG_B;
      MOVI_MEM: b_sel = bus.MEM;
      MOVI_IMM: b_sel = bus.IMM;
      default:  b_sel = '0;
    endcase
  end

  // Capture the request on accept; inputs are ignored afterwards.
  always_ff @(posedge CLK) begin
    if (acc) begin
      op_q <= op_t'(bus.OP);
      a_q  <= bus.REG_A;
      b_q  <= b_sel;
    end
  end

  alu_mul_pipe #(
    .WIDTH      (WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk      (CLK),
    .rst      (RST),
    .a        (bus.REG_A),
    .b        (b_sel),
    .sgn      (bus.OP == OP_MULS),
    .valid    (acc && is_mul(bus.OP)),
    .prod     (prod),
    .prod_vld (prod_vld)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Down-counter covering the extra multiplier latency.
  always_ff @(posedge CLK) begin
    if (RST)                                      wait_cnt <= '0;
    else if (acc)                                 wait_cnt <= WAIT_INIT;
    else if (state == S_MUL_WAIT && wait_cnt != 0) wait_cnt <= wait_cnt - 2'd1;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (acc) begin
          if (is_mul(bus.OP)) state_nxt = (MUL_STAGES > 1) ? S_MUL_WAIT : S_MUL_LO;
`ifdef ALU_DIV_EN
          else if (is_div(bus.OP)) state_nxt = S_DIV;
`endif
          else state_nxt = S_SINGLE;
        end
      end
      S_SINGLE:   state_nxt = S_IDLE;
      S_MUL_WAIT: if (wait_cnt == 0) state_nxt = S_MUL_LO;
      S_MUL_LO:   state_nxt = S_MUL_HI;
      S_MUL_HI:   state_nxt = S_IDLE;
`ifdef ALU_DIV_EN
      S_DIV:      if (div_cnt == 0) state_nxt = S_SINGLE;
`endif
      default:    state_nxt = S_IDLE;
    endcase
  end

`ifdef ALU_DIV_EN
  // Trial subtraction for the restoring divider; bit WIDTH set means it went negative.
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, b_q};
  end

  // Restoring divider: dividend shifts out of quo_q while quotient bits shift in.
  always_ff @(posedge CLK) begin
    if (acc) begin
      quo_q   <= bus.REG_A;
      rem_q   <= '0;
      div_cnt <= SHW'(WIDTH - 1);
    end else if (state == S_DIV) begin
      if (!rem_sub[WIDTH]) begin
        rem_q <= rem_sub[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      div_cnt <= div_cnt - 1'b1;
    end
  end
`endif

  // Shared adder for add/sub/inc/dec; subtraction is x + ~y + 1.
  always_comb begin
    ar_x   = a_q;
    ar_y   = b_q;
    ar_inv = 1'b0;
    case (op_q)
      OP_SUB: ar_inv = 1'b1;
      OP_INC: begin ar_x = b_q; ar_y = WIDTH'(1); end
      OP_DEC: begin ar_x = b_q; ar_y = WIDTH'(1); ar_inv = 1'b1; end
      default: ;
    endcase
    ar_y_eff = ar_inv ? ~ar_y : ar_y;
    ar_sum   = {1'b0, ar_x} + {1'b0, ar_y_eff} + {{WIDTH{1'b0}}, ar_inv};
  end

  // Single-beat result, carry/overflow and error classification.
  always_comb begin
    res      = '0;
    cf       = 1'b0;
    vf       = 1'b0;
    illegal  = 1'b0;
    div_zero = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        res = ar_sum[WIDTH-1:0];
        cf  = ar_sum[WIDTH];
        vf  = (ar_x[WIDTH-1] == ar_y_eff[WIDTH-1]) && (ar_sum[WIDTH-1] != ar_x[WIDTH-1]);
      end
      OP_SRL1: res = a_q >> 1;
      OP_SLL1: res = a_q << 1;
      OP_ROR1: res = {a_q[0], a_q[WIDTH-1:1]};
      OP_ROL1: res = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
      OP_NOT:  res = ~a_q;
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_NAND: res = ~(a_q & b_q);
      OP_NOR:  res = ~(a_q | b_q);
      OP_XNOR: res = ~(a_q ^ b_q);
      OP_SLL:  res = a_q << b_q[SHW-1:0];
      OP_SRL:  res = a_q >> b_q[SHW-1:0];
      OP_SRA:  res = $signed(a_q) >>> b_q[SHW-1:0];
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, a_q < b_q};
`ifdef ALU_DIV_EN
      OP_DIVU: begin res = quo_q; div_zero = (b_q == '0); end
      OP_REMU: begin res = rem_q; div_zero = (b_q == '0); end
`endif
      default: illegal = 1'b1;
    endcase
  end

  // Output beats; everything is zero outside a valid beat.
  always_comb begin
    bus.RDY   = (state == S_IDLE);
    bus.VLD   = 1'b0;
    bus.LAST  = 1'b0;
    bus.DATA  = '0;
    bus.FLAGS = '0;
    bus.ERR   = 1'b0;
    case (state)
      S_SINGLE: begin
        bus.VLD  = 1'b1;
        bus.LAST = 1'b1;
        bus.ERR  = illegal | div_zero;
        if (!illegal) begin
          bus.DATA          = res;
          bus.FLAGS[FLAG_Z] = (res == '0);
          bus.FLAGS[FLAG_N] = res[WIDTH-1];
          bus.FLAGS[FLAG_C] = cf;
          bus.FLAGS[FLAG_V] = vf;
        end
      end
      S_MUL_LO: begin
        if (prod_vld) begin
          bus.VLD  = 1'b1;
          bus.DATA = prod[WIDTH-1:0];
        end
      end
      S_MUL_HI: begin
        bus.VLD           = 1'b1;
        bus.LAST          = 1'b1;
        bus.DATA          = prod[2*WIDTH-1:WIDTH];
        bus.FLAGS[FLAG_Z] = (prod == '0);
        bus.FLAGS[FLAG_N] = prod[2*WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized checks of alu_pipe (WIDTH=32, MUL_STAGES=3)
// against an arithmetic reference model of the opcode table.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int MS = 3;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
`ifdef ALU_DIV_EN
  localparam int DIV_LAT = W + 1;
`endif

  logic CLK;
  logic RST;
  int   n_vec = 0;
  int   n_err = 0;

  alu_pipe_if #(.WIDTH(W)) ifc ();

  alu_pipe #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference: result beats, latency and flags straight from the opcode table.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int nb, output int lat, output logic [31:0] lo,
                                output logic [31:0] hi, output logic [3:0] fl, output logic er);
    longint sa, sb, sr;
    logic [63:0] p;
    logic [32:0] r;
    logic c, v, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nb = 1; lat = 1; lo = '0; hi = '0; fl = '0; er = 1'b0;
    c = 1'b0; v = 1'b0; ill = 1'b0; sr = 0; p = '0;
    case (op)
      OP_ADD:  begin r = 33'(a) + 33'(b); lo = r[31:0]; c = r[32]; sr = sa + sb; v = (sr > SMAX) || (sr < SMIN); end
      OP_SUB:  begin lo = a - b; c = (a >= b); sr = sa - sb; v = (sr > SMAX) || (sr < SMIN); end
      OP_INC:  begin lo = b + 1; c = (b == 32'hFFFFFFFF); v = (sb + 1 > SMAX); end
      OP_DEC:  begin lo = b - 1; c = (b != 0); v = (sb - 1 < SMIN); end
      OP_MUL, OP_MULS: begin
        if (op == OP_MUL) p = 64'(a) * 64'(b);
        else              p = 64'(sa * sb);
        nb = 2; lat = MS; lo = p[31:0]; hi = p[63:32];
        fl = {2'b00, p[63], p == 64'd0};
      end
      OP_SRL1: lo = a >> 1;
      OP_SLL1: lo = a << 1;
      OP_ROR1: lo = (a >> 1) | (a << 31);
      OP_ROL1: lo = (a << 1) | (a >> 31);
      OP_NOT:  lo = ~a;
      OP_AND:  lo = a & b;
      OP_OR:   lo = a | b;
      OP_XOR:  lo = a ^ b;
      OP_NAND: lo = ~(a & b);
      OP_NOR:  lo = ~(a | b);
      OP_XNOR: lo = ~(a ^ b);
      OP_SLL:  lo = a << b[4:0];
      OP_SRL:  lo = a >> b[4:0];
      OP_SRA:  begin sr = sa >>> b[4:0]; lo = sr[31:0]; end
      OP_SLT:  lo = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: lo = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_DIV_EN
      OP_DIVU, OP_REMU: begin
        lat = DIV_LAT;
        if (b == 0) begin
          er = 1'b1;
          lo = (op == OP_DIVU) ? 32'hFFFFFFFF : a;
        end else begin
          lo = (op == OP_DIVU) ? a / b : a % b;
        end
      end
`endif
      default: begin ill = 1'b1; er = 1'b1; end
    endcase
    if (nb == 1 && !ill) fl = {v, c, lo[31], lo == 32'd0};
  endfunction

  // Issue one operation at a negedge and check every cycle until RDY returns.
  task automatic run_op(input logic [4:0] op, input logic [1:0] movi, input logic [31:0] a,
                        input logic [31:0] rb, input logic [31:0] mem, input logic [31:0] imm);
    logic [31:0] b, lo, hi;
    logic [3:0]  fl;
    logic        er;
    int          nb, lat;
    case (movi)
      2'b00:   b = rb;
      2'b01:   b = mem;
      2'b10:   b = imm;
      default: b = 32'd0;
    endcase
    model(op, a, b, nb, lat, lo, hi, fl, er);
    chk("rdy_idle", ifc.RDY, 1);
    ifc.ACT = 1'b1; ifc.OP = op; ifc.MOVI = movi;
    ifc.REG_A = a; ifc.REG_B = rb; ifc.MEM = mem; ifc.IMM = imm;
    @(posedge CLK);
    @(negedge CLK);
    for (int k = 1; k < lat; k++) begin
      ifc.ACT = 1'($urandom); ifc.OP = 5'($urandom); ifc.REG_A = $urandom; ifc.REG_B = $urandom;
      chk("busy_vld", ifc.VLD, 0);
      chk("busy_rdy", ifc.RDY, 0);
      chk("busy_data", ifc.DATA, 0);
      @(negedge CLK);
    end
    if (nb == 2) begin
      chk("lo_vld", ifc.VLD, 1);
      chk("lo_last", ifc.LAST, 0);
      chk("lo_data", ifc.DATA, lo);
      chk("lo_flags", ifc.FLAGS, 0);
      @(negedge CLK);
    end
    chk("fin_vld", ifc.VLD, 1);
    chk("fin_last", ifc.LAST, 1);
    chk("fin_rdy", ifc.RDY, 0);
    chk("fin_data", ifc.DATA, (nb == 2) ? hi : lo);
    chk("fin_flags", ifc.FLAGS, fl);
    chk("fin_err", ifc.ERR, er);
    ifc.ACT = 1'b0;
    @(negedge CLK);
    chk("post_rdy", ifc.RDY, 1);
    chk("post_vld", ifc.VLD, 0);
    chk("post_data", ifc.DATA, 0);
  endtask

  initial begin
    RST = 1'b1;
    ifc.ACT = 1'b0; ifc.OP = '0; ifc.MOVI = '0;
    ifc.REG_A = '0; ifc.REG_B = '0; ifc.MEM = '0; ifc.IMM = '0;
    repeat (2) @(negedge CLK);
    chk("rst_rdy", ifc.RDY, 1);
    chk("rst_vld", ifc.VLD, 0);
    chk("rst_last", ifc.LAST, 0);
    chk("rst_data", ifc.DATA, 0);
    chk("rst_flags", ifc.FLAGS, 0);
    chk("rst_err", ifc.ERR, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Directed cases
    run_op(OP_ADD,  2'b10, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h1);
    chk("add_wrap_flags_const", 4'b0101, ifc.FLAGS === 4'b0000 ? 4'b0101 : 4'b0000);
    run_op(OP_MUL,  2'b00, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0);
    run_op(OP_MULS, 2'b01, 32'hFFFFFFFF, 32'h0, 32'h3, 32'h0);
    run_op(OP_SRA,  2'b10, 32'h80000000, 32'h0, 32'h0, 32'h4);
    run_op(5'h1F,   2'b00, 32'h12345678, 32'h1, 32'h0, 32'h0);
    run_op(OP_SUB,  2'b11, 32'h80000000, 32'h9, 32'h9, 32'h9);
    run_op(OP_SUB,  2'b00, 32'h80000000, 32'h1, 32'h0, 32'h0);
    run_op(OP_DEC,  2'b00, 32'h0,        32'h0, 32'h0, 32'h0);
    run_op(OP_INC,  2'b00, 32'h0,        32'h7FFFFFFF, 32'h0, 32'h0);
    run_op(OP_SLT,  2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    run_op(OP_SLTU, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    run_op(OP_DIVU, 2'b10, 32'd100,      32'h0, 32'h0, 32'd7);
    run_op(OP_REMU, 2'b10, 32'd100,      32'h0, 32'h0, 32'd7);
    run_op(OP_DIVU, 2'b11, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    run_op(OP_REMU, 2'b11, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);

    // ACT held through a MUL: the ADD is taken only once RDY is back.
    ifc.ACT = 1'b1; ifc.OP = OP_MUL; ifc.MOVI = 2'b00;
    ifc.REG_A = 32'h1234; ifc.REG_B = 32'h10;
    @(posedge CLK);
    @(negedge CLK);
    ifc.OP = OP_ADD; ifc.MOVI = 2'b10; ifc.REG_A = 32'h7FFFFFFF; ifc.IMM = 32'h1;
    for (int k = 1; k <= MS + 1; k++) begin
      chk("b2b_busy_rdy", ifc.RDY, 0);
      if (k == MS + 1) chk("b2b_hi_last", ifc.LAST, 1);
      @(negedge CLK);
    end
    chk("b2b_bubble_rdy", ifc.RDY, 1);
    chk("b2b_bubble_vld", ifc.VLD, 0);
    @(negedge CLK);
    chk("b2b_add_vld", ifc.VLD, 1);
    chk("b2b_add_data", ifc.DATA, 32'h80000000);
    chk("b2b_add_flags", ifc.FLAGS, 4'b1010);
    ifc.ACT = 1'b0;
    @(negedge CLK);
    chk("b2b_end_rdy", ifc.RDY, 1);

    // Reset while the low product beat is on the bus.
    ifc.ACT = 1'b1; ifc.OP = OP_MUL; ifc.MOVI = 2'b00;
    ifc.REG_A = 32'hFFFFFFFF; ifc.REG_B = 32'hFFFFFFFF;
    @(posedge CLK);
    @(negedge CLK);
    ifc.ACT = 1'b0;
    repeat (MS - 1) @(negedge CLK);
    chk("rstmul_lo_vld", ifc.VLD, 1);
    chk("rstmul_lo_last", ifc.LAST, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstmul_vld", ifc.VLD, 0);
    chk("rstmul_data", ifc.DATA, 0);
    chk("rstmul_rdy", ifc.RDY, 1);
    RST = 1'b0;
    for (int k = 0; k < MS + 2; k++) begin
      @(negedge CLK);
      chk("rstmul_no_hi", ifc.VLD, 0);
    end
    run_op(OP_MUL, 2'b00, 32'h00010000, 32'h00010000, 32'h0, 32'h0);

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      run_op(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), pick(), pick(), pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised multi-cycle ALU for the execute stage, and the next generation of the current single-width ALU. It adds configurable data width, a pipelined signed/unsigned multiplier with configurable depth, shift-by-amount, compare, and status flags. It keeps the same ACT/RDY/VLD handshake and the same operand-B source select, and returns 2*WIDTH products as two beats, low word first.

Parameters:
WIDTH, 32, datapath width; power of two, minimum 8
MUL_STAGES, 1, cycles from accept to first product beat; legal range 1..4
SHW, $clog2(WIDTH), shift-amount width; derived, do not override

Ports:
CLK  in  1  clock
RST  in  1  reset
ACT  in  1  request; accepted when ACT & RDY
OP  in  5  opcode (see Behaviour)
MOVI  in  2  operand-B select: 00 REG_B, 01 MEM, 10 IMM, 11 zero
REG_A  in  WIDTH  operand A
REG_B  in  WIDTH  register operand B
MEM  in  WIDTH  memory operand B
IMM  in  WIDTH  immediate operand B
DATA  out  WIDTH  result beat; 0 when VLD=0
RDY  out  1  idle, can accept
VLD  out  1  DATA/FLAGS valid this cycle
LAST  out  1  final beat of the operation
FLAGS  out  4  {V,C,N,Z}; valid on LAST beat, otherwise 0
ERR  out  1  illegal opcode, or divide-by-zero with ALU_DIV_EN; valid on LAST beat

Behaviour:
- Reset is RST, synchronous, active-high; clock is CLK. While RST=1 the next edge forces state IDLE, RDY=1, VLD=0, LAST=0, DATA=0, FLAGS=0, ERR=0.
- Reset mid-operation: the operation is aborted, no further beats are produced, and the multiplier pipe contents are discarded.
- Accept: on an edge with ACT & RDY, capture OP, REG_A, and the selected operand B into registers.
- After accept, inputs are don't-care. RDY=0 in every state except IDLE, and ACT is ignored while busy.
- States: IDLE, SINGLE, MUL_WAIT, MUL_LO, MUL_HI, and DIV (macro only).
  - IDLE to SINGLE on accept of a single-beat opcode.
  - IDLE to MUL_WAIT on accept of MUL/MULS when MUL_STAGES>1; directly to MUL_LO when MUL_STAGES=1.
  - MUL_WAIT counts MUL_STAGES-1 cycles, then goes to MUL_LO.
  - MUL_LO goes to MUL_HI; MUL_HI goes to IDLE; SINGLE goes to IDLE.
- Latency: single-beat results appear 1 cycle after accept. The product low word appears MUL_STAGES cycles after accept; the high word follows on the next cycle with LAST=1.
- VLD is high only in SINGLE/MUL_LO/MUL_HI (and the DIV result cycle). RDY returns to 1 the cycle after LAST, so back-to-back issue gives one bubble.
- Opcodes 0x00..0x0F are unchanged from the current ALU: add, sub, mul(unsigned), srl1, sll1, ror1, rol1, not, and, or, xor, nand, nor, xnor, inc B, dec B.
- New opcodes:
  - 0x10 MULS: signed product.
  - 0x11 SLL: A << B[SHW-1:0].
  - 0x12 SRL: A >> B[SHW-1:0].
  - 0x13 SRA: A >>> B[SHW-1:0], arithmetic.
  - 0x14 DIVU, 0x15 REMU: with macro only.
  - 0x16 SLT: signed A<B gives 1, else 0.
  - 0x17 SLTU: unsigned A<B gives 1, else 0.
  - 0x18..0x1F: illegal.
- Illegal opcode: single beat, DATA=0, ERR=1, FLAGS=0.
- Flags:
  - Z: result==0. For products, Z covers the full 2*WIDTH product.
  - N: MSB of the final beat.
  - C: carry out for add/inc; for sub/dec, C=1 means no borrow (A+~B+1). C=0 for all other opcodes.
  - V: signed overflow for add/sub/inc/dec, else 0.

Optional Feature:
ALU_DIV_EN:
- Defined: DIVU/REMU run as an unsigned restoring divider, 1 quotient bit per cycle.
  - State DIV lasts WIDTH cycles; the result beat (VLD=1, LAST=1) appears at accept+WIDTH+1.
  - Divide by zero: quotient all-ones, remainder = A, ERR=1, same latency.
  - Z and N are computed from the returned word; C=V=0.
- Undefined: 0x14/0x15 are illegal opcodes. No divider logic or DIV state is built.

Decomposition:
- Package alu_pkg holds:
  - the op_t enum (5-bit opcodes above), movi_t enum, state_t enum;
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
- One sub-module, alu_mul_pipe, parametrised WIDTH and MUL_STAGES:
  - inputs a, b, signed flag, valid;
  - output is the 2*WIDTH product with a matching valid, retimed over MUL_STAGES registers.
- The divider stays inline behind the macro.

Test Plan:
- WIDTH=32: ADD, MOVI=10, A=0xFFFFFFFF, IMM=1 -> next cycle VLD=1, LAST=1, DATA=0, Z=1, C=1, V=0, then RDY=1.
- MUL_STAGES=1: MUL A=0xFFFFFFFF, B=2 -> accept+1 DATA=0xFFFFFFFE, LAST=0; accept+2 DATA=0x00000001, LAST=1. Repeat with MUL_STAGES=3 -> beats at accept+3 and accept+4.
- MULS A=0xFFFFFFFF, B=3 -> low 0xFFFFFFFD, high 0xFFFFFFFF, N=1. SRA A=0x80000000, B=4 -> DATA=0xF8000000, N=1.
- ACT held high with a MUL followed by an ADD -> ADD accepted only on the edge where RDY=1, the cycle after LAST. OP=0x1F -> DATA=0, ERR=1.
- RST asserted in the MUL_LO cycle -> next cycle VLD=0, DATA=0, RDY=1, and no high beat is ever emitted.
- ALU_DIV_EN, WIDTH=32:
  - DIVU 100/7 -> DATA=14 at accept+33; REMU -> DATA=2.
  - DIVU x/0 -> DATA=0xFFFFFFFF, ERR=1.
  - Without the macro, DIVU -> ERR=1, DATA=0 at accept+1.
